mdu_iter: RTL and testbench

//  Iterative multiply/divide unit for the multicycle MIPS datapath (MULT/MULTU/DIV/DIVU).

---
 rtl/mdu_iter.sv | 159 +++++++++++++++
 tb/tb_mdu_iter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit (MULT/MULTU/DIV/DIVU) producing HI/LO over WIDTH+3 edges.
// Define MDU_EARLY_TERM_EN to let multiplies leave the iteration phase once the multiplier is exhausted.
`timescale 1ns/1ps
module mdu_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

`ifdef MDU_EARLY_TERM_EN
  localparam bit EARLY_TERM = 1'b1;
`else
  localparam bit EARLY_TERM = 1'b0;
`endif

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_ITER, S_FIX, S_DONE} state_t;
  state_t state;

  logic [1:0]         op_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic               neg_p, neg_r;
  logic [2*WIDTH-1:0] acc, mcand;
  logic [WIDTH-1:0]   mplier, quo, rem;
  logic [CNT_W-1:0]   cnt;

  logic               is_div, is_signed, borrow;
  logic [WIDTH-1:0]   abs_a, abs_b, mplier_nx, rem_nx, quo_fix, rem_fix;
  logic [WIDTH:0]     rem_sh;
  logic [2*WIDTH-1:0] prod_fix;

  always_comb begin
    is_div    = op_q[1];
    is_signed = ~op_q[0];
    abs_a     = (is_signed && a_q[WIDTH-1]) ? -a_q : a_q;
    abs_b     = (is_signed && b_q[WIDTH-1]) ? -b_q : b_q;
    mplier_nx = mplier >> 1;
    // rem_sh is the WIDTH+1-bit partial remainder; after a successful subtract it fits in WIDTH bits
    rem_sh    = {rem, quo[WIDTH-1]};
    borrow    = rem_sh < {1'b0, b_q};
    rem_nx    = borrow ? rem_sh[WIDTH-1:0] : rem_sh[WIDTH-1:0] - b_q;
    prod_fix  = neg_p ? -acc : acc;
    quo_fix   = neg_p ? -quo : quo;
    rem_fix   = neg_r ? -rem : rem;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      neg_p       <= 1'b0;
      neg_r       <= 1'b0;
      acc         <= '0;
      mcand       <= '0;
      mplier      <= '0;
      quo         <= '0;
      rem         <= '0;
      cnt         <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            op_q        <= op;
            a_q         <= a;
            b_q         <= b;
            div_by_zero <= 1'b0;
            busy        <= 1'b1;
            state       <= S_PREP;
          end
        end
        S_PREP: begin
          if (flush) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            // b_q is replaced by |b| and then serves as the divisor; a_q keeps the raw dividend
            neg_p  <= is_signed && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
            neg_r  <= is_signed && a_q[WIDTH-1];
            b_q    <= abs_b;
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, abs_a};
            mplier <= abs_b;
            quo    <= abs_a;
            rem    <= '0;
            cnt    <= '0;
            state  <= (EARLY_TERM && !is_div && abs_b == '0) ? S_FIX : S_ITER;
          end
        end
        S_ITER: begin
          if (flush) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            if (is_div) begin
              rem <= rem_nx;
              quo <= {quo[WIDTH-2:0], ~borrow};
            end else begin
              if (mplier[0])
                acc <= acc + mcand;
              mcand  <= mcand << 1;
              mplier <= mplier_nx;
            end
            cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(WIDTH-1) || (EARLY_TERM && !is_div && mplier_nx == '0))
              state <= S_FIX;
          end
        end
        S_FIX: begin
          if (flush) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            if (!is_div) begin
              hi <= prod_fix[2*WIDTH-1:WIDTH];
              lo <= prod_fix[WIDTH-1:0];
            end else if (b_q == '0) begin
              hi <= a_q;
              lo <= '1;
            end else begin
              hi <= rem_fix;
              lo <= quo_fix;
            end
            div_by_zero <= is_div && (b_q == '0);
            done        <= 1'b1;
            state       <= S_DONE;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Scoreboard testbench for mdu_iter: randomized and directed ops checked against an arithmetic model.
`timescale 1ns/1ps
module tb_mdu_iter;
  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [1:0]       op = '0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             flush = 1'b0;
  logic             busy, done, div_by_zero;
  logic [WIDTH-1:0] hi, lo;

  mdu_iter #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .flush(flush),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int unsigned cyc;
  } exp_t;

  exp_t        sbq[$];
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_hi = '0;
  logic [31:0] last_lo = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t        e;
    longint      sx, sy, q, r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    e.dbz = 1'b0;
    e.cyc = 0;
    e.hi  = '0;
    e.lo  = '0;
    case (o)
      2'b00: begin p = sx * sy; e.hi = p[63:32]; e.lo = p[31:0]; end
      2'b01: begin p = {32'b0, x} * {32'b0, y}; e.hi = p[63:32]; e.lo = p[31:0]; end
      default: begin
        if (y == 0) begin
          e.hi = x; e.lo = 32'hFFFF_FFFF; e.dbz = 1'b1;
        end else if (o == 2'b10) begin
          q = sx / sy; r = sx % sy;
          e.hi = r[31:0]; e.lo = q[31:0];
        end else begin
          e.hi = x % y; e.lo = x / y;
        end
      end
    endcase
    return e;
  endfunction

  // Edges from the accepting edge to the edge that raises done.
  function automatic int unsigned lat(input logic [1:0] o, input logic [31:0] y);
`ifdef MDU_EARLY_TERM_EN
    logic [31:0] m;
    int unsigned k;
    if (!o[1]) begin
      m = (o == 2'b00 && y[31]) ? -y : y;
      k = 0;
      while (m != 0) begin m = m >> 1; k++; end
      return 2 + k;
    end
`endif
    return WIDTH + 2;
  endfunction

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 255));
      default: return 32'($urandom);
    endcase
  endfunction

  task automatic wait_idle();
    int unsigned n = 0;
    while (busy && n < 200) begin @(negedge clk); n++; end
    check("idle_timeout", {31'b0, busy}, 32'd0);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input bit expect_it, input bit with_flush);
    exp_t e;
    wait_idle();
    start = 1'b1; op = o; a = x; b = y; flush = with_flush;
    if (expect_it) begin
      e = model(o, x, y);
      e.cyc = cyc + 1 + lat(o, y);
      sbq.push_back(e);
      last_hi = e.hi;
      last_lo = e.lo;
    end
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    a = $urandom; b = $urandom; op = 2'($urandom);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done) begin
        if (sbq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got done=1 expected no pending op at cycle %0d", cyc);
        end else begin
          e = sbq.pop_front();
          check("hi", hi, e.hi);
          check("lo", lo, e.lo);
          check("div_by_zero", {31'b0, div_by_zero}, {31'b0, e.dbz});
          check("done_cycle", cyc, e.cyc);
          check("busy_in_done", {31'b0, busy}, 32'd1);
        end
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_dbz", {31'b0, div_by_zero}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0);
    issue(2'b00, 32'hFFFF_FFFD, 32'd7, 1, 0);
    issue(2'b00, 32'h8000_0000, 32'h8000_0000, 1, 0);
    issue(2'b10, 32'hFFFF_FFF9, 32'd2, 1, 0);
    issue(2'b10, 32'd7, 32'hFFFF_FFFE, 1, 0);
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1, 0);
    issue(2'b11, 32'd5, 32'd0, 1, 0);
    issue(2'b11, 32'd9, 32'd4, 1, 0);
    check("dbz_clear_on_start", {31'b0, div_by_zero}, 32'd0);
    issue(2'b10, 32'hFFFF_FFF0, 32'd0, 1, 0);
    issue(2'b01, 32'd1234, 32'd0, 1, 0);
    issue(2'b01, 32'd1234, 32'd1, 1, 0);

    // start while busy is ignored
    issue(2'b11, 32'd1000, 32'd7, 1, 0);
    repeat (9) @(negedge clk);
    start = 1'b1; op = 2'b01; a = 32'd3; b = 32'd5;
    @(negedge clk);
    start = 1'b0;

    // flush mid-iteration: no done, hi/lo untouched
    issue(2'b11, 32'd12345, 32'd17, 0, 0);
    repeat (14) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", {31'b0, busy}, 32'd0);
    check("flush_hi_kept", hi, last_hi);
    check("flush_lo_kept", lo, last_lo);
    repeat (40) @(negedge clk);

    // start wins over flush in IDLE
    issue(2'b00, 32'hFFFF_FF00, 32'h0000_0013, 1, 1);

    // reset mid-operation
    issue(2'b10, 32'd999, 32'd3, 0, 0);
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_hi", hi, 32'd0);
    check("midrst_lo", lo, 32'd0);
    check("midrst_dbz", {31'b0, div_by_zero}, 32'd0);
    repeat (40) @(negedge clk);

    for (int i = 0; i < 60; i++)
      issue(2'($urandom), rnd_val(), rnd_val(), 1, 0);

    wait_idle();
    repeat (5) @(negedge clk);
    check("pending_results", sbq.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
